// File: rtl/stopwatch_pkg.sv
// Shared state encodings and default timing constants for the stopwatch sequencer.
// Latency: none (declarations only); backpressure: none.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  localparam int TICK_DIV_DEF  = 1000000;
  localparam int DB_CYCLES_DEF = 200000;

  // States in which the prescaler advances and count ticks are produced.
  function automatic logic is_counting(input sw_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_sequencer_debounce.sv
// Button front end: 2-FF synchronizer, debouncer, rising-edge press pulse.
// Latency: press pulse DB_CYCLES+2 edges after first sampled high; backpressure: none.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control FSM: debounced buttons drive IDLE/RUN/PAUSE/LAP, prescaler and counter pulses.
// Latency: state changes DB_CYCLES+3 edges after a clean press; backpressure: none.
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_lap,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_freeze,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          start_ev;
  logic          stop_ev;
  logic          lap_ev;
  sw_state_t     cur;
  sw_state_t     nxt;
  logic [PW-1:0] presc;
  logic          keep_counting;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_stop),
    .press (stop_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .press (lap_ev)
  );

  // Priority stop > start > lap; a losing event in the same cycle is dropped.
  always_comb begin
    nxt = cur;
    if (stop_ev) begin
      nxt = IDLE;
    end else if (start_ev) begin
      case (cur)
        IDLE:    nxt = RUN;
        RUN:     nxt = PAUSE;
        PAUSE:   nxt = RUN;
        LAP:     nxt = PAUSE;
        default: nxt = cur;
      endcase
    end else if (lap_ev) begin
      case (cur)
        RUN:     nxt = LAP;
        LAP:     nxt = RUN;
        default: nxt = cur;
      endcase
    end
  end

  // Leaving RUN/LAP freezes the prescaler and suppresses a tick on that same cycle.
  assign keep_counting = is_counting(cur) && is_counting(nxt);
  assign cnt_en        = keep_counting && (presc == PRESC_LAST);
  assign state         = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= IDLE;
      presc       <= '0;
      cnt_clr     <= 1'b0;
      lap_load    <= 1'b0;
      disp_freeze <= 1'b0;
    end else begin
      cur         <= nxt;
      cnt_clr     <= stop_ev;
      lap_load    <= (cur == RUN) && (nxt == LAP);
      disp_freeze <= (nxt == LAP);
      if (nxt == IDLE) begin
        presc <= '0;
      end else if (keep_counting) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end
    end
  end

endmodule

// File: doc/stopwatch_sequencer.md
STOPWATCH_SEQUENCER -- requirements
Module: stopwatch_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per count tick (100 Hz at 100 MHz); legal range >= 2.
REQ-002 Parameter DB_CYCLES, default 200000, consecutive stable cycles required to accept a button level change; legal range >= 1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_start  input  1  raw start/pause button, asynchronous, active-high, bouncy.
REQ-006 btn_stop  input  1  raw stop/clear button, asynchronous, active-high, bouncy.
REQ-007 btn_lap  input  1  raw lap button, asynchronous, active-high, bouncy.
REQ-008 cnt_en  output  1  one-cycle count-tick pulse to the time counter.
REQ-009 cnt_clr  output  1  one-cycle clear pulse to the time counter.
REQ-010 lap_load  output  1  one-cycle pulse: display register captures the current count.
REQ-011 disp_freeze  output  1  level: display shows the captured lap value, not the live count.
REQ-012 state  output  2  current state code: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-013 Each button SHALL pass through a 2-FF synchronizer, then a debouncer whose accepted level changes only after DB_CYCLES consecutive cycles with the synchronized level different from the accepted level; any mismatch-free interruption restarts the count.
REQ-014 A press event SHALL be a one-cycle pulse on the 0->1 transition of the accepted level; release generates no event; a held button generates exactly one event.
REQ-015 State SHALL change on the clock edge following the press-event cycle; total latency from the first edge sampling a clean raw high to the state change is DB_CYCLES+3 edges.
REQ-016 Transitions: IDLE+start->RUN; RUN+start->PAUSE; PAUSE+start->RUN; RUN+lap->LAP; LAP+lap->RUN; LAP+start->PAUSE; any state+stop->IDLE.
REQ-017 Lap in IDLE or PAUSE and start... no-ops SHALL leave the state unchanged; stop in IDLE SHALL still pulse cnt_clr.
REQ-018 Simultaneous events in one cycle: priority stop > start > lap; lower-priority events that cycle are discarded.
REQ-019 Prescaler SHALL increment every cycle in RUN and LAP, hold in PAUSE, and be 0 in IDLE.
REQ-020 When the prescaler equals TICK_DIV-1 in RUN or LAP, cnt_en SHALL be 1 for that cycle and the prescaler SHALL wrap to 0; the first tick after IDLE->RUN occurs TICK_DIV cycles after entry.
REQ-021 cnt_en SHALL never be asserted in IDLE or PAUSE, including the cycle of a RUN->PAUSE transition edge.
REQ-022 cnt_clr SHALL be 1 for exactly the cycle after a stop event is accepted.
REQ-023 lap_load SHALL be 1 for exactly the first cycle in LAP after a RUN->LAP transition.
REQ-024 disp_freeze SHALL equal 1 exactly while state is LAP.
REQ-025 Prescaler width SHALL be $clog2(TICK_DIV); debounce counter width $clog2(DB_CYCLES+1); no overflow possible.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE, prescaler=0, debounce counters=0, accepted levels=0, synchronizers=0, and cnt_en, cnt_clr, lap_load, disp_freeze=0.
REQ-027 A button held through reset release SHALL produce one press event after DB_CYCLES+2 cycles (accepted level starts at 0).
REQ-028 Reset asserted mid-RUN or mid-LAP SHALL abandon the operation with no cnt_clr pulse; the counter block is reset by the same signal.

Structure
REQ-029 Shared package stopwatch_pkg SHALL hold the state encodings (IDLE, RUN, PAUSE, LAP) and default TICK_DIV/DB_CYCLES constants.
REQ-030 The synchronizer+debouncer+edge detector SHALL be one sub-module, btn_debounce, instantiated three times; FSM, prescaler and output pulses stay in stopwatch_sequencer.

Verification (TICK_DIV=4, DB_CYCLES=3)
REQ-031 btn_start clean press from IDLE -> state=01 at edge 6 after first sampled high; cnt_en pulses every 4 cycles, first pulse 4 cycles after entry.
REQ-032 btn_start bouncing 1-0-1-0 at 1-cycle intervals, then held high -> exactly one RUN entry, exactly DB_CYCLES+3 edges after the final stable rise.
REQ-033 RUN with prescaler=2, start press -> PAUSE, no cnt_en; start press again -> RUN, first cnt_en 1 cycle later (prescaler resumes from 2 -> 3).
REQ-034 RUN, lap press -> state=11, lap_load one cycle, disp_freeze=1, cnt_en continues every 4 cycles; lap again -> state=01, disp_freeze=0.
REQ-035 start and stop events in the same cycle from RUN -> state=00, cnt_clr one cycle, prescaler=0, no PAUSE.
REQ-036 reset low mid-LAP -> all outputs 0 and state=00 immediately, before next clk edge.
